eat_score_keeper: RTL

Consumer side of the fish field's eat-event outputs. Edge-detects the nine per-fish eat flags for each player, serialises the events through a round-robin scan, and accumulates saturating scores and player levels. It raises game-over when a player reaches the win score, and, optionally, issues timed per-fish respawn pulses back toward the fish field. Sits between the fish field and the HUD/colour mapper in the top level.

---
 rtl/eat_score_keeper.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/eat_score_keeper.sv
// Eat-event consumer: edge-detects per-fish eat flags, serialises credits through a
// round-robin scan, keeps saturating scores/levels and game state. Optional respawn timers: EAT_SCORE_RESPAWN_EN.
module eat_score_keeper #(
    parameter int PTS_UNIT       = 4,
    parameter int LVL1           = 40,
    parameter int LVL2           = 100,
    parameter int LVL3           = 200,
    parameter int WIN_SCORE      = 300,
    parameter int RESPAWN_FRAMES = 90
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        is_start,
    input  logic [8:0]  user1_eat,
    input  logic [8:0]  user2_eat,
    output logic [11:0] user1_score,
    output logic [11:0] user2_score,
    output logic [1:0]  user1_level,
    output logic [1:0]  user2_level,
    output logic        game_over,
    output logic        winner,
    output logic [8:0]  respawn_req
);

    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

    localparam logic [11:0] LVL1_C = 12'(LVL1);
    localparam logic [11:0] LVL2_C = 12'(LVL2);
    localparam logic [11:0] LVL3_C = 12'(LVL3);
    localparam logic [11:0] WIN_C  = 12'(WIN_SCORE);

    state_t      state, state_nxt;
    logic        start_q;
    logic        start_edge;
    logic        in_run;
    logic        win_hit;
    logic [8:0]  prev1, prev2;
    logic [8:0]  edge1, edge2;
    logic [8:0]  pend_valid, pend_user;
    logic [8:0]  pend_valid_nxt, pend_user_nxt;
    logic [3:0]  ptr;
    logic        credit;
    logic        credit_user;
    logic [11:0] credit_pts;
    logic [2:0]  fsync;
    logic        tick_q;

    function automatic logic [11:0] sat_add(input logic [11:0] a, input logic [11:0] b);
        logic [12:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[12] ? 12'hFFF : s[11:0];
    endfunction

    function automatic logic [1:0] level_of(input logic [11:0] s);
        if (s < LVL1_C)      return 2'd0;
        else if (s < LVL2_C) return 2'd1;
        else if (s < LVL3_C) return 2'd2;
        else                 return 2'd3;
    endfunction

    assign start_edge  = is_start & ~start_q;
    assign in_run      = (state == RUN);
    assign win_hit     = (user1_score >= WIN_C) || (user2_score >= WIN_C);
    assign edge1       = user1_eat & ~prev1 & {9{in_run}};
    assign edge2       = user2_eat & ~prev2 & {9{in_run}};
    // Once a winning score lands, no further credit may slip in before OVER takes effect
    assign credit      = in_run && !win_hit && pend_valid[ptr];
    assign credit_user = pend_user[ptr];
    assign credit_pts  = 12'((int'(ptr) + 1) * PTS_UNIT);
    assign game_over   = (state == OVER);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = IDLE;
            RUN:     if (win_hit) state_nxt = OVER;
            OVER:    state_nxt = OVER;
            default: state_nxt = IDLE;
        endcase
        if (start_edge) state_nxt = RUN;
    end

    // A pending slot ignores new edges until the scan has credited it
    always_comb begin
        pend_valid_nxt = pend_valid;
        pend_user_nxt  = pend_user;
        for (int i = 0; i < 9; i++) begin
            if (pend_valid[i]) begin
                if (credit && ptr == 4'(i)) pend_valid_nxt[i] = 1'b0;
            end else if (edge1[i] || edge2[i]) begin
                pend_valid_nxt[i] = 1'b1;
                pend_user_nxt[i]  = ~edge1[i];
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            start_q     <= 1'b0;
            prev1       <= '0;
            prev2       <= '0;
            pend_valid  <= '0;
            pend_user   <= '0;
            ptr         <= '0;
            user1_score <= '0;
            user2_score <= '0;
            user1_level <= '0;
            user2_level <= '0;
            winner      <= 1'b0;
        end else begin
            start_q <= is_start;
            state   <= state_nxt;
            if (start_edge) begin
                pend_valid  <= '0;
                pend_user   <= '0;
                user1_score <= '0;
                user2_score <= '0;
                user1_level <= '0;
                user2_level <= '0;
                winner      <= 1'b0;
            end else if (in_run) begin
                prev1      <= user1_eat;
                prev2      <= user2_eat;
                ptr        <= (ptr == 4'd8) ? 4'd0 : ptr + 4'd1;
                pend_valid <= pend_valid_nxt;
                pend_user  <= pend_user_nxt;
                if (credit) begin
                    winner <= credit_user;
                    if (credit_user) user2_score <= sat_add(user2_score, credit_pts);
                    else             user1_score <= sat_add(user1_score, credit_pts);
                end
                user1_level <= level_of(user1_score);
                user2_level <= level_of(user2_score);
            end else begin
                pend_valid <= '0;
                pend_user  <= '0;
            end
        end
    end

    // frame_clk crosses domains through two flops; third flop is edge history
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fsync  <= '0;
            tick_q <= 1'b0;
        end else begin
            fsync  <= {fsync[1:0], frame_clk};
            tick_q <= fsync[1] & ~fsync[2];
        end
    end

`ifdef EAT_SCORE_RESPAWN_EN
    localparam logic [7:0] RF_C = 8'(RESPAWN_FRAMES);

    logic [7:0] timer [9];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 9; i++) timer[i] <= '0;
        end else if (start_edge) begin
            for (int i = 0; i < 9; i++) timer[i] <= '0;
        end else if (in_run) begin
            for (int i = 0; i < 9; i++) begin
                if (credit && ptr == 4'(i))
                    timer[i] <= RF_C;
                else if (tick_q && timer[i] != 8'd0)
                    timer[i] <= timer[i] - 8'd1;
            end
        end
    end

    // A reload on the expiring tick suppresses the pulse
    always_comb begin
        respawn_req = '0;
        for (int i = 0; i < 9; i++)
            respawn_req[i] = in_run && !start_edge && tick_q && (timer[i] == 8'd1) &&
                             !(credit && ptr == 4'(i));
    end
`else
    // Frame tick has no consumer without respawn timers
    assign respawn_req = {9{tick_q & 1'b0}};
`endif

endmodule
